// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, bouncy, asynchronous pushbutton pin into a clean synchronous
// level plus single-cycle event pulses for the downstream pushbutton/LED
// control stage.
//
// Processing chain:
//   btn_raw -> SYNC_STAGES-flop synchroniser -> btn_s
//   btn_s   -> 4-state stability filter (S_LOW / S_RISE_CHK / S_HIGH /
//              S_FALL_CHK) with a debounce counter -> btn_clean + pulses
//   btn_clean -> hold counter -> long_press
//
// A new level is accepted only after btn_s has held it for DEBOUNCE_CYCLES
// consecutive samples. Any opposite sample during a check, including on the
// final counting edge, throws the candidate away. From a clean raw transition
// (set up before edge e1), btn_clean and its pulse change on edge
// e(SYNC_STAGES + DEBOUNCE_CYCLES).
//
// Parameters:
//   SYNC_STAGES       synchroniser depth on btn_raw (>= 2)
//   DEBOUNCE_CYCLES   cycles a new level must be stable before acceptance (>= 2)
//   LONG_PRESS_CYCLES cycles btn_clean must stay high before long_press (>= 1)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset; clears every flop
//   btn_raw       raw pushbutton pin, 1 = pressed
//   btn_clean     debounced level
//   press_pulse   one-cycle pulse on an accepted 0->1 transition
//   release_pulse one-cycle pulse on an accepted 1->0 transition
//   long_press    one-cycle pulse, at most once per press, when the hold time
//                 reaches LONG_PRESS_CYCLES
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    // -------------------------------------------------------------------------
    // Parameter legality: refuse to elaborate outside the supported range.
    // -------------------------------------------------------------------------
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("button_debouncer: SYNC_STAGES must be 2 or more");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
            $error("button_debouncer: DEBOUNCE_CYCLES must be 2 or more");
        end
        if (LONG_PRESS_CYCLES < 1) begin : g_bad_long_press_cycles
            $error("button_debouncer: LONG_PRESS_CYCLES must be 1 or more");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Widths and counter constants
    // -------------------------------------------------------------------------
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    // The count reaches DEBOUNCE_CYCLES-1 before the edge that commits, so
    // the commit edge itself is the DEBOUNCE_CYCLES-th stable sample.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,  // stable 0
        S_RISE_CHK = 2'd1,  // candidate 1, counting
        S_HIGH     = 2'd2,  // stable 1
        S_FALL_CHK = 2'd3   // candidate 0, counting
    } state_t;

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    // NOTE: sequential state uses non-blocking (<=) assignments so every flop
    // samples the pre-edge value of its neighbours; blocking (=) here would
    // collapse the synchroniser chain into a single flop in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Only the last synchroniser stage is safe to look at.
    assign btn_s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Stability filter FSM: state register
    // -------------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [DEB_W-1:0]    deb_cnt, deb_nxt;
    logic                clean_nxt;
    logic                press_nxt;
    logic                release_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_LOW;
            deb_cnt       <= '0;
            btn_clean     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            btn_clean     <= clean_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Stability filter FSM: next state and registered-output inputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case can leave one unassigned and infer a latch.
        state_nxt   = state;
        deb_nxt     = '0;          // stable states keep the counter cleared
        clean_nxt   = btn_clean;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;

        unique case (state)
            S_LOW: begin
                if (btn_s) begin
                    state_nxt = S_RISE_CHK;
                    deb_nxt   = DEB_ONE;
                end
            end

            S_RISE_CHK: begin
                if (!btn_s) begin
                    // Glitch: drop the candidate silently.
                    state_nxt = S_LOW;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = S_HIGH;
                    clean_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    state_nxt = S_RISE_CHK;
                    deb_nxt   = deb_cnt + DEB_ONE;
                end
            end

            S_HIGH: begin
                if (!btn_s) begin
                    state_nxt = S_FALL_CHK;
                    deb_nxt   = DEB_ONE;
                end
            end

            S_FALL_CHK: begin
                if (btn_s) begin
                    // Release bounce: back to stable high, hold time kept.
                    state_nxt = S_HIGH;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = S_LOW;
                    clean_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    state_nxt = S_FALL_CHK;
                    deb_nxt   = deb_cnt + DEB_ONE;
                end
            end

            default: begin
                state_nxt = S_LOW;
                clean_nxt = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Long-press detection
    //
    // hold_cnt counts cycles with btn_clean high (S_HIGH and S_FALL_CHK alike),
    // so an aborted release bounce does not disturb it. It saturates at
    // LONG_PRESS_CYCLES; because long_press only fires on the increment that
    // lands on that value, it can fire at most once per press. Both commit
    // edges clear the count.
    // -------------------------------------------------------------------------
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              long_nxt;

    always_comb begin
        hold_nxt = hold_cnt;
        long_nxt = 1'b0;

        if (press_nxt || release_nxt) begin
            hold_nxt = '0;
        end else if (btn_clean && (hold_cnt != HOLD_MAX)) begin
            hold_nxt = hold_cnt + HOLD_ONE;
            long_nxt = (hold_cnt == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            hold_cnt   <= hold_nxt;
            long_press <= long_nxt;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=8,
// LONG_PRESS_CYCLES=32. Each scenario fills a table of {btn_raw, expected
// {btn_clean, press_pulse, release_pulse, long_press}} records, one per clock
// edge, then plays it back. Edge numbers inside a table count from 1 at the
// first edge after btn_raw takes the first table value. Async reset behaviour
// is checked by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int SYNC_STAGES       = 2;
    localparam int DEBOUNCE_CYCLES   = 8;
    localparam int LONG_PRESS_CYCLES = 32;

    logic clk;
    logic rst_n;
    logic btn_raw;
    logic btn_clean;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    button_debouncer #(
        .SYNC_STAGES      (SYNC_STAGES),
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_clean    (btn_clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {btn_clean, press_pulse, release_pulse, long_press}
    typedef struct {
        logic       raw;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fails = 0;

    function automatic logic [3:0] outs();
        return {btn_clean, press_pulse, release_pulse, long_press};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got clean/press/release/long=%b, want %b", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled here
    // and the next input value is set up well before the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic raw, input logic [3:0] exp);
        vec_t v;
        v.raw = raw;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic play(input string name);
        foreach (vecs[i]) begin
            btn_raw = vecs[i].raw;
            tick();
            check($sformatf("%s edge %0d", name, i + 1), outs(), vecs[i].exp);
        end
        vecs.delete();
    endtask

    // Held button after reset release: commit on edge 10, then release it
    // (release commits 10 edges after btn_raw drops) and idle.
    task automatic requalify_and_release(input string name);
        for (int i = 1; i <= 12; i++)
            add(1'b1, (i == 10) ? 4'b1100 : (i > 10) ? 4'b1000 : 4'b0000);
        for (int i = 1; i <= 15; i++)
            add(1'b0, (i < 10) ? 4'b1000 : (i == 10) ? 4'b0010 : 4'b0000);
        play(name);
    endtask

    initial begin
        rst_n   = 1'b1;
        btn_raw = 1'b1;
        #2;
        rst_n   = 1'b0;

        // ---------------- Reset held with button pressed ----------------
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("reset hold cycle %0d", i), outs(), 4'b0000);
        end
        rst_n = 1'b1;
        requalify_and_release("reset release");

        // ---------------- Clean press / release ----------------
        // Rise before edge 1 -> press at 10; fall before edge 50 -> release
        // at 59. Held long enough for long_press at 10 + 32 = 42.
        for (int i = 1; i <= 70; i++)
            add(i <= 49, {(i >= 10 && i <= 58), (i == 10), (i == 59), (i == 42)});
        play("clean");

        // ---------------- Bounce rejection ----------------
        // Toggle every 3 cycles for 40 cycles (last toggle to 1 before edge
        // 41), hold to edge 55, then release from edge 56.
        for (int i = 1; i <= 70; i++) begin
            logic raw;
            if (i <= 40)      raw = (((i - 1) / 3) % 2) == 0;
            else if (i <= 55) raw = 1'b1;
            else              raw = 1'b0;
            add(raw, {(i >= 50 && i <= 64), (i == 50), (i == 65), 1'b0});
        end
        play("bounce");

        // ---------------- Last-edge glitch ----------------
        // btn_s high for 7 samples, then low on the edge that would commit.
        // Re-qualification from raw rise before edge 9 commits on edge 18.
        for (int i = 1; i <= 40; i++)
            add((i <= 24) && (i != 8), {(i >= 18 && i <= 33), (i == 18), (i == 34), 1'b0});
        play("last-edge glitch");

        // ---------------- Long press with release bounce ----------------
        // Held 100 cycles, 2-cycle low at raw cycles 20-21 (aborted release).
        for (int i = 1; i <= 115; i++)
            add((i <= 100) && (i != 20) && (i != 21),
                {(i >= 10 && i <= 109), (i == 10), (i == 110), (i == 42)});
        play("long press");

        // ---------------- Short press after a long one ----------------
        for (int i = 1; i <= 35; i++)
            add(i <= 20, {(i >= 10 && i <= 29), (i == 10), (i == 30), 1'b0});
        play("short press");

        // ---------------- Reset while held ----------------
        for (int i = 1; i <= 15; i++)
            add(1'b1, (i == 10) ? 4'b1100 : (i > 10) ? 4'b1000 : 4'b0000);
        play("pre-reset press");
        rst_n = 1'b0;
        #1;
        check("async reset drop", outs(), 4'b0000);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("mid-hold reset cycle %0d", i), outs(), 4'b0000);
        end
        rst_n = 1'b1;
        requalify_and_release("post-reset requalify");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw mechanical pushbutton into a clean, synchronous level plus single-cycle event pulses.
- Sits directly upstream of the pushbutton/LED control stage: btn_clean drives that stage's pushbutton input.
- Pipeline: input synchroniser, counter-based stability filter (4-state FSM), edge-pulse generation, and long-press detection.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_raw; legal range is 2 or more.
- DEBOUNCE_CYCLES, 500000, consecutive clock cycles the synchronised input must hold a new level before it is accepted (10 ms at 50 MHz); legal range is 2 or more.
- LONG_PRESS_CYCLES, 50000000, cycles btn_clean must stay high after its rising edge before long_press fires (1 s at 50 MHz); legal range is 1 or more.

Ports:
- clk  input  1  system clock; all flops on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  1  raw pushbutton pin; asynchronous and bouncy; 1 = pressed.
- btn_clean  output  1  debounced, synchronous button level.
- press_pulse  output  1  one-cycle pulse on an accepted 0->1 transition.
- release_pulse  output  1  one-cycle pulse on an accepted 1->0 transition.
- long_press  output  1  one-cycle pulse once per press when the hold time reaches LONG_PRESS_CYCLES.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- While rst_n=0, all flops clear immediately: synchroniser chain=0, counters=0, FSM=S_LOW, and btn_clean, press_pulse, release_pulse, long_press all =0.
- Synchroniser: btn_raw passes through SYNC_STAGES flops. btn_s is the last flop output and is the only signal the FSM samples.
- FSM states:
  - S_LOW (stable 0).
  - S_RISE_CHK (candidate 1).
  - S_HIGH (stable 1).
  - S_FALL_CHK (candidate 0).
- Debounce counter, deb_cnt: width $clog2(DEBOUNCE_CYCLES+1); cleared in every stable state.
- S_LOW transitions:
  - btn_s=1 -> S_RISE_CHK with deb_cnt=1.
  - Otherwise stay.
- S_RISE_CHK transitions:
  - btn_s=0 -> S_LOW and deb_cnt=0 (glitch rejected, no outputs).
  - btn_s=1 and deb_cnt=DEBOUNCE_CYCLES-1 -> S_HIGH; btn_clean<=1 and press_pulse<=1 on this same edge.
  - Otherwise deb_cnt++.
- S_HIGH and S_FALL_CHK mirror S_LOW and S_RISE_CHK with polarity inverted. The commit edge sets btn_clean<=0 and release_pulse<=1.
- Latency: a clean raw transition (setup met before edge e1) changes btn_clean on edge e(SYNC_STAGES+DEBOUNCE_CYCLES). The pulse is registered and coincides with the btn_clean change.
- Glitch rules:
  - Any opposite-level btn_s sample during a CHK state, including on the final counting edge, aborts the check with no commit.
  - A later re-qualification restarts from deb_cnt=1.
- Pulses: press_pulse and release_pulse are high for exactly one cycle and are never high together.
- Long press: hold counter hold_cnt, width $clog2(LONG_PRESS_CYCLES+1).
  - Cleared on every press commit.
  - Increments each cycle btn_clean=1, in both S_HIGH and S_FALL_CHK.
  - Saturates at LONG_PRESS_CYCLES.
  - long_press pulses for one cycle on the edge hold_cnt reaches LONG_PRESS_CYCLES, at most once per press.
  - hold_cnt clears on release commit.
  - A release bounce that aborts (S_FALL_CHK -> S_HIGH) does not clear hold_cnt.
- Reset mid-operation:
  - Asserted while the button is held: outputs drop asynchronously.
  - After deassertion, a still-held button is qualified as a new press (press_pulse after the full latency).
  - No release_pulse is ever generated by reset.
- Out-of-range parameters are not supported; elaboration fails on a SYNC_STAGES, DEBOUNCE_CYCLES or LONG_PRESS_CYCLES value below its legal range.

Test Plan:
- All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32.
- Reset: hold rst_n=0 with btn_raw=1 for 5 cycles -> all outputs 0 throughout. Release rst_n -> btn_clean rises exactly 10 edges later with a single press_pulse.
- Clean press/release: btn_raw 0->1 before edge 1 -> btn_clean=1 and press_pulse=1 at edge 10 only. btn_raw 1->0 before edge 50 -> btn_clean=0 and release_pulse=1 at edge 59 only.
- Bounce rejection: btn_raw toggles every 3 cycles for 40 cycles, then settles at 1 -> btn_clean stays 0 until 10 edges after the final toggle; exactly one press_pulse.
- Last-edge glitch: btn_raw high for 7 synchronised cycles, then a 1-cycle low -> no commit. Held high afterwards -> press commits 8 cycles after the glitch clears at btn_s.
- Long press: hold for 100 cycles -> long_press pulses once, exactly 32 edges after press_pulse. A 2-cycle release bounce at cycle 20 -> no extra or missing long_press. Release -> release_pulse; the next short press (<32 cycles) -> no long_press.
- Reset mid-hold: assert rst_n after btn_clean=1 -> btn_clean drops asynchronously with no release_pulse. Release rst_n with btn_raw=1 -> new press_pulse 10 edges later.
